// File: rtl/vga_static_if.sv
// vga_static_if
// Bundles the colour input and the VGA connector outputs of the static-colour
// VGA timing generator.
//   data     : RGB332 colour word shown on every visible pixel
//   hs, vs   : horizontal / vertical sync, active low
//   r, g, b  : 3/3/2-bit colour towards the resistor DAC
// master : the timing generator (drives syncs and colour, reads data)
// slave  : whoever supplies data and watches the connector side
`timescale 1ns/1ps
interface vga_static_if;
  logic [7:0] data;
  logic       hs;
  logic       vs;
  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;

  modport master (
    input  data,
    output hs,
    output vs,
    output r,
    output g,
    output b
  );

  modport slave (
    output data,
    input  hs,
    input  vs,
    input  r,
    input  g,
    input  b
  );
endinterface

// File: rtl/vga_static.sv
// vga_static
// Static-colour VGA timing generator, 640x480 @ 60 Hz with default parameters.
// The system clock is divided down to a pixel tick; horizontal and vertical
// counters scan the frame and every visible pixel shows the colour on data,
// while blanking forces the colour to zero.
// Ports:
//   clk    : system clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   vga    : vga_static_if.master (data in; hs, vs, r, g, b out)
// Parameters:
//   CLK_DIV                         : system clocks per pixel (>= 1)
//   H_VISIBLE/H_FP/H_SYNC/H_BP      : horizontal timing in pixels
//   V_VISIBLE/V_FP/V_SYNC/V_BP      : vertical timing in lines
`timescale 1ns/1ps
module vga_static #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_static_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // A divider of 1 still needs a one-bit register; it simply stays at zero.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);

  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic             pix_en;
  logic [9:0]       h;
  logic [9:0]       v;

  logic             visible;
  logic             hs_next;
  logic             vs_next;
  logic [2:0]       r_next;
  logic [2:0]       g_next;
  logic [1:0]       b_next;

  logic             hs_q;
  logic             vs_q;
  logic [2:0]       r_q;
  logic [2:0]       g_q;
  logic [1:0]       b_q;

  // Pixel tick on the last count of the divider, so the first tick after
  // reset lands on the CLK_DIV-th rising edge.
  assign pix_en = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (pix_en) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // The vertical counter only moves on the tick that ends a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v <= '0;
        end else begin
          v <= v + 10'd1;
        end
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Decode of the current counter position; data passes straight through
  // here, so a change on data shows up at the very next tick.
  always_comb begin
    visible = (h < H_VIS_END) && (v < V_VIS_END);
    hs_next = !((h >= HS_FIRST) && (h <= HS_LAST));
    vs_next = !((v >= VS_FIRST) && (v <= VS_LAST));
    r_next  = 3'd0;
    g_next  = 3'd0;
    b_next  = 2'd0;
    if (visible) begin
      r_next = vga.data[7:5];
      g_next = vga.data[4:2];
      b_next = vga.data[1:0];
    end
  end

  // Outputs trail the counters by one tick and hold between ticks, which
  // keeps the DAC free of combinational glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      r_q  <= 3'd0;
      g_q  <= 3'd0;
      b_q  <= 2'd0;
    end else if (pix_en) begin
      hs_q <= hs_next;
      vs_q <= vs_next;
      r_q  <= r_next;
      g_q  <= g_next;
      b_q  <= b_next;
    end
  end

  assign vga.hs = hs_q;
  assign vga.vs = vs_q;
  assign vga.r  = r_q;
  assign vga.g  = g_q;
  assign vga.b  = b_q;

endmodule

// File: tb/tb_vga_static.sv
// tb_vga_static
// Bench for vga_static. Instance dut0 runs the default 640x480 timing with
// CLK_DIV=4; instance dut1 uses CLK_DIV=1 with a shortened vertical timing
// so that whole frames fit in a short run. Expected values are hand-derived
// edge positions: after release, edge 4*k is the tick that decodes h=k-1.
`timescale 1ns/1ps
module tb_vga_static;

  logic clk = 1'b0;
  logic rst_n0;
  logic rst_n1;

  vga_static_if bus0 ();
  vga_static_if bus1 ();

  vga_static dut0 (
    .clk   (clk),
    .rst_n (rst_n0),
    .vga   (bus0.master)
  );

  vga_static #(
    .CLK_DIV   (1),
    .V_VISIBLE (4),
    .V_FP      (2),
    .V_SYNC    (2),
    .V_BP      (2)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .vga   (bus1.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at_edge;
    logic [7:0] data;
    logic       hs;
    logic       vs;
    logic [7:0] colour;
  } vec_t;

  vec_t vecs [12];

  int compared   = 0;
  int mismatched = 0;
  int edge_cnt   = 0;

  logic       sel1;
  logic       probe_hs;
  logic       probe_vs;
  logic [7:0] probe_col;

  // One probe point so the pulse measurement can watch either instance.
  always_comb begin
    probe_hs  = sel1 ? bus1.hs : bus0.hs;
    probe_vs  = sel1 ? bus1.vs : bus0.vs;
    probe_col = sel1 ? {bus1.r, bus1.g, bus1.b} : {bus0.r, bus0.g, bus0.b};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    bus0.data = d;
  endtask

  task automatic advance_to(input int e);
    bit moved;
    moved = 1'b0;
    while (edge_cnt < e) begin
      @(posedge clk);
      edge_cnt++;
      moved = 1'b1;
    end
    if (moved) #1;
  endtask

  task automatic release_reset0();
    @(negedge clk);
    rst_n0   = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic check_dut0(input string tag, input logic hs, input logic vs, input logic [7:0] col);
    checkOutput({tag, "_hs"}, 32'(bus0.hs), 32'(hs));
    checkOutput({tag, "_vs"}, 32'(bus0.vs), 32'(vs));
    checkOutput({tag, "_col"}, 32'({bus0.r, bus0.g, bus0.b}), 32'(col));
  endtask

  task automatic run_table(input string pass);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].data);
      advance_to(vecs[i].at_edge);
      check_dut0($sformatf("%s_e%0d", pass, vecs[i].at_edge), vecs[i].hs, vecs[i].vs, vecs[i].colour);
    end
  endtask

  // Measures, in clk edges, the low width and period of hs or vs on the probe,
  // plus how many samples carry a nonzero colour over one period and over the
  // low phase alone.
  task automatic measure_pulse(input bit use_vs, input int budget,
                               output int low_w, output int per,
                               output int col_cnt, output int col_low, output bit ok);
    int n;
    int t_fall;
    int t_rise;
    int t_fall2;
    logic prev;
    logic cur;
    n = 0; t_fall = -1; t_rise = -1; t_fall2 = -1;
    col_cnt = 0; col_low = 0;
    prev = use_vs ? probe_vs : probe_hs;
    while (n < budget && t_fall2 < 0) begin
      @(posedge clk);
      #1;
      n++;
      cur = use_vs ? probe_vs : probe_hs;
      if (prev && !cur) begin
        if (t_fall < 0) t_fall = n;
        else if (t_rise >= 0) t_fall2 = n;
      end
      if (!prev && cur && t_fall >= 0 && t_rise < 0) t_rise = n;
      if (t_fall >= 0 && t_fall2 < 0 && probe_col != 8'd0) col_cnt++;
      if (t_fall >= 0 && t_rise < 0 && probe_col != 8'd0) col_low++;
      prev = cur;
    end
    ok    = (t_fall2 >= 0);
    low_w = t_rise - t_fall;
    per   = t_fall2 - t_fall;
  endtask

  int low_w;
  int per;
  int col_cnt;
  int col_low;
  bit ok;

  initial begin
    vecs[0]  = '{0,    8'h55, 1'b1, 1'b1, 8'h00};
    vecs[1]  = '{3,    8'h55, 1'b1, 1'b1, 8'h00};
    vecs[2]  = '{4,    8'h55, 1'b1, 1'b1, 8'h55};
    vecs[3]  = '{6,    8'h55, 1'b1, 1'b1, 8'h55};
    vecs[4]  = '{2560, 8'h55, 1'b1, 1'b1, 8'h55};
    vecs[5]  = '{2564, 8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[6]  = '{2624, 8'h55, 1'b1, 1'b1, 8'h00};
    vecs[7]  = '{2628, 8'h55, 1'b0, 1'b1, 8'h00};
    vecs[8]  = '{3008, 8'h55, 1'b0, 1'b1, 8'h00};
    vecs[9]  = '{3012, 8'h55, 1'b1, 1'b1, 8'h00};
    vecs[10] = '{3200, 8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[11] = '{3204, 8'h55, 1'b1, 1'b1, 8'h55};

    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    sel1   = 1'b0;
    bus0.data = 8'h55;
    bus1.data = 8'h55;

    // Held in reset with clocks running: outputs stay at reset values.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_dut0($sformatf("rst_hold%0d", i), 1'b1, 1'b1, 8'h00);
    end

    release_reset0();
    run_table("run1");

    // Reset asserted during hs low of line 1 (edge 5828 decodes h=656).
    advance_to(5828);
    check_dut0("pre_reset", 1'b0, 1'b1, 8'h00);
    #1;
    rst_n0 = 1'b0;
    #1;
    check_dut0("async_reset", 1'b1, 1'b1, 8'h00);
    release_reset0();
    run_table("run2");

    // Mid-line colour change: edge 3600 decodes h=99 of line 1.
    advance_to(3600);
    applyStimulus(8'hE0);
    advance_to(3602);
    check_dut0("chg_hold", 1'b1, 1'b1, 8'h55);
    advance_to(3604);
    check_dut0("chg_new", 1'b1, 1'b1, 8'hE0);
    advance_to(5760);
    check_dut0("chg_last_vis", 1'b1, 1'b1, 8'hE0);
    advance_to(5764);
    check_dut0("chg_blank", 1'b1, 1'b1, 8'h00);

    // Line timing at CLK_DIV=4.
    sel1 = 1'b0;
    measure_pulse(1'b0, 8000, low_w, per, col_cnt, col_low, ok);
    checkOutput("div4_hs_found", 32'(ok), 32'd1);
    if (ok) begin
      checkOutput("div4_hs_low", low_w, 384);
      checkOutput("div4_hs_period", per, 3200);
      checkOutput("div4_col_per_line", col_cnt, 2560);
    end

    // CLK_DIV=1 instance with a 10-line frame.
    @(negedge clk);
    rst_n1 = 1'b1;
    sel1   = 1'b1;
    measure_pulse(1'b0, 3000, low_w, per, col_cnt, col_low, ok);
    checkOutput("div1_hs_found", 32'(ok), 32'd1);
    if (ok) begin
      checkOutput("div1_hs_low", low_w, 96);
      checkOutput("div1_hs_period", per, 800);
      checkOutput("div1_col_per_line", col_cnt, 640);
    end
    measure_pulse(1'b1, 20000, low_w, per, col_cnt, col_low, ok);
    checkOutput("div1_vs_found", 32'(ok), 32'd1);
    if (ok) begin
      checkOutput("div1_vs_low", low_w, 1600);
      checkOutput("div1_vs_period", per, 8000);
      checkOutput("div1_col_per_frame", col_cnt, 2560);
      checkOutput("div1_col_in_vsync", col_low, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
